// File: rtl/stage_responder_if.sv
// Purpose: handshake and coordinate bus between a stage responder and the
//          pipeline control unit / stage datapath.
// Signals:
//   enable    - stage enable level from the control unit
//   done      - stage-complete level back to the control unit
//   busy      - stage is scanning or draining
//   pix_valid - coordinate presented to the datapath
//   pix_ready - datapath accepts the current coordinate
//   pix_x/y   - current column / row
//   pix_sof   - first coordinate of the frame
//   pix_eol   - last column of a line
//   pix_eof   - last coordinate of the frame
// Modports: master = stage responder, slave = control unit / datapath side.
interface stage_responder_if;
    logic       enable;
    logic       done;
    logic       busy;
    logic       pix_valid;
    logic       pix_ready;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;

    modport master (
        input  enable, pix_ready,
        output done, busy, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        output enable, pix_ready,
        input  done, busy, pix_valid, pix_x, pix_y, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/stage_responder.sv
// Purpose: walks one frame of pixel coordinates in raster order under a
//          4-phase enable/done handshake, then flushes the datapath pipeline
//          for DRAIN_CYCLES cycles before reporting completion.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - stage_responder_if.master (enable/done/busy + pixel coordinate bus)
module stage_responder #(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    stage_responder_if.master     bus
);
    localparam int unsigned CW = 10;
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            valid_q, busy_q, done_q;
    logic            sof_q, eol_q, eof_q;
    logic            last_x_c, last_y_c;

    assign last_x_c = (x_q == CW'(IMG_WIDTH - 1));
    assign last_y_c = (y_q == CW'(IMG_HEIGHT - 1));

    // Next-state and counter update; enable low in RUN/DRAIN aborts first.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (bus.pix_ready) begin
                    if (last_x_c && last_y_c) begin
                        // Coordinates stay on the final pixel until the next frame.
                        state_d = DRAIN;
                        cnt_d   = DW'(DRAIN_CYCLES);
                    end else if (last_x_c) begin
                        x_d = '0;
                        y_d = y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; flags are derived from next state
    // so they line up with the coordinates they qualify.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            valid_q <= (state_d == RUN);
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            // done trails DONE entry/exit by one cycle.
            done_q  <= (state_q == DONE);
            sof_q   <= (state_d == RUN) && (x_d == '0) && (y_d == '0);
            eol_q   <= (state_d == RUN) && (x_d == CW'(IMG_WIDTH - 1));
            eof_q   <= (state_d == RUN) && (x_d == CW'(IMG_WIDTH - 1))
                       && (y_d == CW'(IMG_HEIGHT - 1));
        end
    end

    assign bus.pix_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_sof   = sof_q;
    assign bus.pix_eol   = eol_q;
    assign bus.pix_eof   = eof_q;
endmodule
